tile_loader: RTL
================

# tile_loader

Stream-to-tile write engine sitting directly upstream of the 8×8 tile data RAM. It accepts a byte stream over a valid/ready handshake, generates the RAM write enable, address and data for one full tile, and signals completion. The tile is held until the downstream compute stage acknowledges it has consumed the RAM's flattened tile output. The block is the only writer of the tile RAM.

## Interface
- `ROWS`, default 8: tile rows.
- `COLS`, default 8: tile columns.
- `CH`, default 1: channels per pixel.
- `DEPTH`, fixed at `ROWS*COLS*CH`, not overridable: bytes per tile.
- `AW`, fixed at `$clog2(DEPTH)`: RAM address width.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to load a tile; honoured only in IDLE.
- `abort`  in  1  cancels the load in progress.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `ram_wen`  out  1  RAM write enable.
- `ram_waddr`  out  AW  RAM write address.
- `ram_din`  out  8  RAM write data.
- `busy`  out  1  high in LOAD or DRAIN.
- `tile_done`  out  1  tile fully committed to RAM; high in DONE.
- `tile_ack`  in  1  consumer finished reading the tile.
- `transpose`  in  1  present only with `TILE_LOADER_TRANSPOSE_EN`.

## Operation
- States:
  - IDLE → LOAD on `start`.
  - LOAD → DRAIN on accepting byte `DEPTH-1`.
  - DRAIN → DONE unconditionally after 1 cycle.
  - DONE → IDLE on `tile_ack`.
  - LOAD or DRAIN → IDLE on `abort`.
- `s_ready = (state==LOAD) && !abort`. A byte is accepted when `s_valid && s_ready`.
- Address generation uses three counters: ch (fastest), col, then row.
  - Address is `(row*COLS+col)*CH+ch`.
  - All counters clear on entry to LOAD.
- Every accepted byte produces exactly one write on the next cycle. `ram_wen`, `ram_waddr` and `ram_din` are registered. No write occurs for non-accepted cycles.
- `abort` clears the pending-write register, so no write is issued in the cycle after `abort`. A write already on the outputs in the abort cycle still completes.
- `start` outside IDLE is ignored. `tile_ack` outside DONE is ignored.
- In DONE, if `start` and `tile_ack` are asserted together, the block goes to IDLE and `start` is dropped.
- Asynchronous `rst` in any state:
  - State returns to IDLE and all counters clear.
  - All outputs go to 0 immediately.
  - A pending write is lost.

## Timing
- Reset values: `s_ready`=0, `ram_wen`=0, `ram_waddr`=0, `ram_din`=0, `busy`=0, `tile_done`=0.
- Write latency: byte accepted in cycle N appears on `ram_wen`/`ram_waddr`/`ram_din` in cycle N+1. The RAM commits it at the end of N+1.
- Last byte accepted in cycle N:
  - DRAIN occupies N+1 and carries the last write.
  - `tile_done` goes high from N+2 and the RAM holds the full tile.
- Minimum tile time with continuous `s_valid`: 1 start cycle + `DEPTH` accept cycles + 1 DRAIN cycle.
- `tile_done` drops in the cycle after `tile_ack` is sampled.
- `s_ready` is high from the cycle after `start`.

## Configuration
- `TILE_LOADER_TRANSPOSE_EN` defined:
  - The `transpose` port exists and is sampled on the accepted `start`.
  - When `transpose`=1, counter nesting is ch fastest, then row, then col, so a column-major stream lands in row-major RAM order.
  - When `transpose`=0, behaviour matches the undefined case.
- `TILE_LOADER_TRANSPOSE_EN` undefined: the port is absent and ordering is row-major only.

## Test plan
- **Continuous load.** Reset, `start`, then stream bytes 0x00..0x3F with `s_valid` held high.
  - Expect 64 `ram_wen` pulses with `ram_waddr`=k and `ram_din`=k.
  - `tile_done`=1 two cycles after the last accept; RAM output byte i = i.
- **Stream gaps.** `s_valid` toggles every cycle, data 0x00..0x3F.
  - Expect exactly 64 writes, in order, with no duplicates.
  - `s_ready` stays high throughout LOAD.
- **Transpose (macro on).** `transpose`=1, stream k=0..63.
  - Byte k is written to address `(k%8)*8+k/8`: byte 1 → addr 8, byte 9 → addr 9, byte 63 → addr 63.
- **Abort.** Assert `abort` in the cycle byte 20 is offered.
  - Byte 20 is not accepted; byte 19's write completes.
  - `ram_wen`=0 in the next cycle, state goes to IDLE, `busy`=0.
  - A new `start` writes from addr 0.
- **DONE handshake.** In DONE, pulse `start` alone: ignored, `tile_done` stays 1.
  - Pulse `tile_ack`: `tile_done`=0 in the next cycle, state IDLE.
- **Reset mid-load.** Assert `rst` after byte 30 is accepted.
  - All outputs go to 0 immediately, with no write for byte 30.
  - After release, `start` plus 64 bytes completes normally.

Source files
------------

// File: rtl/tile_loader.sv
// Stream-to-tile write engine: turns a valid/ready byte stream into registered RAM writes for one tile.
// Optional macro TILE_LOADER_TRANSPOSE_EN adds the transpose port (column-major stream ordering).
module tile_loader #(
   parameter  int ROWS  = 8,
   parameter  int COLS  = 8,
   parameter  int CH    = 1,
   localparam int DEPTH = ROWS * COLS * CH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
   output logic          s_ready,
   output logic          ram_wen,
   output logic [AW-1:0] ram_waddr,
   output logic [7:0]    ram_din,
   output logic          busy,
   output logic          tile_done,
`ifdef TILE_LOADER_TRANSPOSE_EN
   input  logic          transpose,
`endif
   input  logic          tile_ack
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int HW = (CH   > 1) ? $clog2(CH)   : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] row, row_nxt;
   logic [CW-1:0] col, col_nxt;
   logic [HW-1:0] ch,  ch_nxt;
   logic          tr;
   logic          accept, row_last, col_last, ch_last, last;
   logic [AW-1:0] addr;

   assign s_ready   = (state == LOAD) && !abort;
   assign busy      = (state == LOAD) || (state == DRAIN);
   assign tile_done = (state == DONE);
   assign accept    = s_valid && s_ready;

   assign row_last = (row == RW'(ROWS - 1));
   assign col_last = (col == CW'(COLS - 1));
   assign ch_last  = (ch  == HW'(CH - 1));
   // All counters at their maximum identifies the final byte for either nesting order.
   assign last     = accept && row_last && col_last && ch_last;

   assign addr = AW'((int'(row) * COLS + int'(col)) * CH + int'(ch));

`ifdef TILE_LOADER_TRANSPOSE_EN
   logic tr_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        tr_q <= 1'b0;
      else if (state == IDLE && start) tr_q <= transpose;
   end
   assign tr = tr_q;
`else
   assign tr = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD:  if (abort) state_nxt = IDLE;
                else if (last) state_nxt = DRAIN;
         DRAIN: state_nxt = abort ? IDLE : DONE;
         DONE:  if (tile_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ch always fastest; tr selects whether row or col is the middle counter.
   always_comb begin
      ch_nxt  = ch + 1'b1;
      row_nxt = row;
      col_nxt = col;
      if (ch_last) begin
         ch_nxt = '0;
         if (tr) begin
            row_nxt = row_last ? '0 : row + 1'b1;
            if (row_last) col_nxt = col_last ? '0 : col + 1'b1;
         end else begin
            col_nxt = col_last ? '0 : col + 1'b1;
            if (col_last) row_nxt = row_last ? '0 : row + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
         ch  <= '0;
      end else if (state == IDLE && start) begin
         row <= '0;
         col <= '0;
         ch  <= '0;
      end else if (accept) begin
         row <= row_nxt;
         col <= col_nxt;
         ch  <= ch_nxt;
      end
   end

   // accept already excludes abort cycles, so no write follows an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_wen   <= 1'b0;
         ram_waddr <= '0;
         ram_din   <= '0;
      end else begin
         ram_wen <= accept;
         if (accept) begin
            ram_waddr <= addr;
            ram_din   <= s_data;
         end
      end
   end

endmodule
